// File: rtl/uart_rx_pkt_reader.sv
// uart_rx_pkt_reader
// Drains the UART receive FIFO and rebuilds framed packets of the form
// SOF, LEN, LEN payload bytes, CHK where CHK is the XOR of LEN and every
// payload byte. Validated payloads are replayed on a valid/ready byte stream.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   flush        synchronous abort back to HUNT (no error reported)
//   rx_empty     UART RX FIFO empty
//   rdata        UART RX FIFO head byte (first-word fall-through)
//   rd           RX FIFO pop (combinational)
//   m_data       output payload byte
//   m_valid      output byte valid
//   m_ready      downstream accepts the byte
//   m_last       final payload byte of the packet
//   m_len        length of the packet being drained
//   pkt_ok       one-cycle pulse: packet validated
//   pkt_err      one-cycle pulse: packet dropped
//   err_code     last error: 1 bad length, 2 bad checksum, 3 timeout
//   err_count    dropped-packet count, saturating at 255
//   busy         reader is not hunting for a start-of-frame byte
module uart_rx_pkt_reader #(
    parameter int             MDW     = 8,
    parameter int             BAW     = 4,
    parameter logic [MDW-1:0] SOF     = 8'hA5,
    parameter int             TOW     = 16,
    parameter int             TIMEOUT = 1000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           rx_empty,
    input  logic [MDW-1:0] rdata,
    output logic           rd,
    output logic [MDW-1:0] m_data,
    output logic           m_valid,
    input  logic           m_ready,
    output logic           m_last,
    output logic [BAW:0]   m_len,
    output logic           pkt_ok,
    output logic           pkt_err,
    output logic [1:0]     err_code,
    output logic [7:0]     err_count,
    output logic           busy
);

    typedef enum logic [2:0] {
        ST_HUNT  = 3'd0,
        ST_LEN   = 3'd1,
        ST_PAY   = 3'd2,
        ST_CHK   = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam logic [BAW:0]   ONE_L     = (BAW+1)'(1);
    localparam logic [MDW:0]   MAX_LEN_V = (MDW+1)'(2**BAW);
    localparam logic [TOW-1:0] TO_LAST   = TOW'(TIMEOUT - 1);
    localparam logic [TOW-1:0] TO_ONE    = TOW'(1);

    // Running checksum step: XOR fold of one byte into the accumulator.
    function automatic logic [MDW-1:0] chk_fold(input logic [MDW-1:0] acc,
                                                input logic [MDW-1:0] b);
        return acc ^ b;
    endfunction

    // Saturating increment for the dropped-packet counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

    state_t           state_r, state_s;
    logic [BAW:0]     len_r, idx_r, ridx_r, m_len_r;
    logic [MDW-1:0]   chk_r;
    logic [TOW-1:0]   tcnt_r;
    logic [MDW-1:0]   buf_r [0:(2**BAW)-1];
    logic             pkt_ok_r, pkt_err_r;
    logic [1:0]       err_code_r;
    logic [7:0]       err_count_r;

    logic             rd_s, busy_s, m_valid_s, m_last_s;
    logic [MDW-1:0]   m_data_s;
    logic             in_frame_s, len_bad_s, last_pay_s, chk_match_s;
    logic             hs_s, hs_last_s, tmo_s;
    logic             ok_s, err_s;
    logic [1:0]       code_s;

    assign in_frame_s  = (state_r == ST_LEN) || (state_r == ST_PAY) || (state_r == ST_CHK);
    assign len_bad_s   = (rdata == '0) || ({1'b0, rdata} > MAX_LEN_V);
    assign last_pay_s  = ((idx_r + ONE_L) == len_r);
    assign chk_match_s = (rdata == chk_r);
    assign hs_s        = (state_r == ST_DRAIN) && m_ready;
    assign hs_last_s   = hs_s && (ridx_r == (len_r - ONE_L));
    // The timeout fires on the idle cycle that would bring the count to TIMEOUT.
    assign tmo_s       = in_frame_s && !rd_s && (tcnt_r == TO_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_HUNT;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic plus error/accept event decode; flush overrides everything.
    always_comb begin
        state_s = state_r;
        ok_s    = 1'b0;
        err_s   = 1'b0;
        code_s  = 2'd0;
        if (flush) begin
            state_s = ST_HUNT;
        end else begin
            case (state_r)
                ST_HUNT: begin
                    if (rd_s && (rdata == SOF)) begin
                        state_s = ST_LEN;
                    end else begin
                        state_s = ST_HUNT;
                    end
                end
                ST_LEN: begin
                    if (rd_s) begin
                        if (len_bad_s) begin
                            state_s = ST_HUNT;
                            err_s   = 1'b1;
                            code_s  = 2'd1;
                        end else begin
                            state_s = ST_PAY;
                        end
                    end else if (tmo_s) begin
                        state_s = ST_HUNT;
                        err_s   = 1'b1;
                        code_s  = 2'd3;
                    end else begin
                        state_s = ST_LEN;
                    end
                end
                ST_PAY: begin
                    if (rd_s) begin
                        if (last_pay_s) begin
                            state_s = ST_CHK;
                        end else begin
                            state_s = ST_PAY;
                        end
                    end else if (tmo_s) begin
                        state_s = ST_HUNT;
                        err_s   = 1'b1;
                        code_s  = 2'd3;
                    end else begin
                        state_s = ST_PAY;
                    end
                end
                ST_CHK: begin
                    if (rd_s) begin
                        if (chk_match_s) begin
                            state_s = ST_DRAIN;
                            ok_s    = 1'b1;
                        end else begin
                            state_s = ST_HUNT;
                            err_s   = 1'b1;
                            code_s  = 2'd2;
                        end
                    end else if (tmo_s) begin
                        state_s = ST_HUNT;
                        err_s   = 1'b1;
                        code_s  = 2'd3;
                    end else begin
                        state_s = ST_CHK;
                    end
                end
                ST_DRAIN: begin
                    if (hs_last_s) begin
                        state_s = ST_HUNT;
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end
                default: begin
                    state_s = ST_HUNT;
                end
            endcase
        end
    end

    // Output decode from the state register; pops are blocked in reset, flush and DRAIN.
    always_comb begin
        rd_s      = 1'b0;
        busy_s    = 1'b0;
        m_valid_s = 1'b0;
        m_data_s  = '0;
        m_last_s  = 1'b0;
        case (state_r)
            ST_HUNT, ST_LEN, ST_PAY, ST_CHK: begin
                rd_s   = rst_n && !rx_empty && !flush;
                busy_s = (state_r != ST_HUNT);
            end
            ST_DRAIN: begin
                busy_s    = 1'b1;
                m_valid_s = 1'b1;
                m_data_s  = buf_r[ridx_r[BAW-1:0]];
                m_last_s  = (ridx_r == (len_r - ONE_L));
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Frame datapath: length, checksum, indices, idle counter and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_r       <= '0;
            idx_r       <= '0;
            ridx_r      <= '0;
            m_len_r     <= '0;
            chk_r       <= '0;
            tcnt_r      <= '0;
            pkt_ok_r    <= 1'b0;
            pkt_err_r   <= 1'b0;
            err_code_r  <= 2'd0;
            err_count_r <= 8'd0;
        end else if (flush) begin
            idx_r     <= '0;
            ridx_r    <= '0;
            tcnt_r    <= '0;
            pkt_ok_r  <= 1'b0;
            pkt_err_r <= 1'b0;
        end else begin
            pkt_ok_r  <= ok_s;
            pkt_err_r <= err_s;
            if (err_s) begin
                err_code_r  <= code_s;
                err_count_r <= sat_inc(err_count_r);
            end
            if (rd_s || err_s || !in_frame_s) begin
                tcnt_r <= '0;
            end else begin
                tcnt_r <= tcnt_r + TO_ONE;
            end
            if ((state_r == ST_LEN) && rd_s) begin
                len_r <= rdata[BAW:0];
                chk_r <= rdata;
                idx_r <= '0;
            end
            if ((state_r == ST_PAY) && rd_s) begin
                chk_r <= chk_fold(chk_r, rdata);
                idx_r <= idx_r + ONE_L;
            end
            if (ok_s) begin
                ridx_r  <= '0;
                m_len_r <= len_r;
            end else if (hs_s) begin
                ridx_r <= hs_last_s ? '0 : (ridx_r + ONE_L);
            end
        end
    end

    // Payload buffer; contents are only observed in DRAIN so it needs no reset.
    always_ff @(posedge clk) begin
        if ((state_r == ST_PAY) && rd_s) begin
            buf_r[idx_r[BAW-1:0]] <= rdata;
        end
    end

    assign rd        = rd_s;
    assign busy      = busy_s;
    assign m_valid   = m_valid_s;
    assign m_data    = m_data_s;
    assign m_last    = m_last_s;
    assign m_len     = m_len_r;
    assign pkt_ok    = pkt_ok_r;
    assign pkt_err   = pkt_err_r;
    assign err_code  = err_code_r;
    assign err_count = err_count_r;

endmodule

// File: doc/uart_rx_pkt_reader.md
# uart_rx_pkt_reader

Host-side packet reader that drains the receive FIFO of the UART core and rebuilds framed packets from the byte stream. It pops bytes through the UART's `rd`/`rdata`/`rx_empty` FIFO read port, hunts for a start-of-frame byte, and checks length and XOR checksum. It buffers the payload and releases validated packets on a valid/ready byte stream toward the FEC datapath. It is the consumer counterpart to the bench/host logic that fills the UART transmit FIFO.

## Interface
- `MDW`, 8: byte width; must match the UART `MDW`.
- `BAW`, 4: payload buffer address width; the maximum payload is 2**BAW bytes.
- `SOF`, 8'hA5: start-of-frame byte.
- `TOW`, 16: timeout counter width.
- `TIMEOUT`, 1000: idle cycles allowed between bytes inside a frame.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `flush`  in  1  synchronous abort to HUNT.
- `rx_empty`  in  1  UART RX FIFO empty.
- `rdata`  in  MDW  UART RX FIFO head byte; first-word fall-through, valid whenever `rx_empty`=0.
- `rd`  out  1  RX FIFO pop.
- `m_data`  out  MDW  output payload byte.
- `m_valid`  out  1  output byte valid.
- `m_ready`  in  1  downstream accepts the byte.
- `m_last`  out  1  final payload byte of the packet.
- `m_len`  out  BAW+1  length of the packet being drained.
- `pkt_ok`  out  1  one-cycle pulse: packet validated.
- `pkt_err`  out  1  one-cycle pulse: packet dropped.
- `err_code`  out  2  last error: 1 bad length, 2 bad checksum, 3 timeout; 0 after reset.
- `err_count`  out  8  dropped-packet count; saturates at 255.
- `busy`  out  1  state ≠ HUNT.

## Operation
- Frame format: SOF, LEN, LEN payload bytes, CHK.
  - CHK = XOR of LEN and every payload byte.
- `rd` is combinational: `rd` = (state ∈ {HUNT, LEN, PAY, CHK}) & !`rx_empty` & !`flush`.
  - A byte is consumed when `rd`=1; `rdata` is sampled in that same cycle.
  - Back-to-back pops are allowed, at most one per cycle.
- **HUNT:** discard bytes ≠ SOF. SOF → LEN.
- **LEN:**
  - LEN=0 or LEN > 2**BAW → error 1, back to HUNT.
  - Otherwise store the length, seed the checksum with LEN, clear the write index, go to PAY.
- **PAY:** write each byte to `buf[idx]`, XOR it into the checksum, increment idx. After LEN bytes → CHK.
- **CHK:**
  - Byte == checksum → DRAIN; `pkt_ok` pulses.
  - Byte ≠ checksum → error 2, back to HUNT.
- **DRAIN:** no pops.
  - `m_valid`=1, `m_data`=`buf[ridx]`, `m_last`=(`ridx`==LEN−1).
  - Each `m_valid`&`m_ready` advances `ridx`. The handshake on `m_last` → HUNT.
- **Timeout:** in LEN/PAY/CHK, the idle counter increments on each cycle with no pop and clears on each pop. Reaching TIMEOUT → error 3, back to HUNT.
- **On every error:** `pkt_err` pulses, `err_code` is updated, `err_count` += 1 (saturating at 255).
- **Flush:** synchronous, has priority over all other events. Next state is HUNT; indices and the timeout counter clear; `m_valid`=0. No `pkt_err`, and `err_code`/`err_count` are unchanged.
- An SOF byte inside LEN/PAY/CHK is treated as data; there is no resync mid-frame.

## Timing
- **Reset values:** state HUNT, `m_valid`=0, `m_last`=0, `m_data`=0, `m_len`=0, `pkt_ok`=0, `pkt_err`=0, `err_code`=0, `err_count`=0, `busy`=0. `rd`=0 while `rst_n`=0.
- **Latency:** CHK popped at cycle t → state DRAIN, `m_valid`=1 with `buf[0]`, and `pkt_ok`=1, all at t+1.
- **Error pulse:** error detected at cycle t → `pkt_err`=1 at t+1; state is HUNT at t+1, so a pop can occur at t+1.
- **Timeout:** fires on the TIMEOUT-th consecutive idle cycle after the last pop.
- **Last handshake:** last byte handshake at t → HUNT at t+1, `m_valid`=0, `rd` may assert at t+1.
- **Stability:** `m_data`, `m_last` and `m_len` are held stable while `m_valid`=1 and `m_ready`=0.
- **Reset mid-operation:** asynchronous return to reset values. The partial packet is lost and no `pkt_err` is raised.

## Test plan
- **Good packet:** A5,02,11,22,31 in the FIFO → 2 pops of payload; `pkt_ok` one cycle after the CHK pop. `m_data` 11 then 22 with `m_last` on 22, `m_len`=2. Exactly 5 `rd` pulses.
- **Bad checksum:** A5,02,11,22,30 → `pkt_err`, `err_code`=2, `err_count`=1, no `m_valid`. A following good packet is then delivered.
- **Length errors:**
  - A5,00 → `err_code`=1.
  - A5,11 (17 > 16) → `err_code`=1.
  - Preceding junk bytes 00,FF before SOF are discarded silently.
- **Timeout:** A5,03,01 then the FIFO stays empty → `pkt_err` at TIMEOUT idle cycles +1, `err_code`=3, `busy`=0.
- **Backpressure:** good 16-byte packet (max length) with `m_ready` toggling 1/0 → all 16 bytes in order, held stable while stalled, `m_last` only on byte 15, `rd`=0 throughout DRAIN.
- **Abort:** `flush` after A5,04,AA → HUNT with no `pkt_err`, and the next packet is correct. `rst_n` low during DRAIN → all outputs at reset values immediately.
